// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard and stall controller for a 5-stage in-order pipeline. It handles
//   data-memory freezes, taken-branch redirects, load-use stalls and
//   instruction-fetch stalls. The pipeline control outputs are Mealy, so they
//   react in the same cycle as the inputs that cause them.
//
// Ports
//   clk, reset              clock; asynchronous active-low reset
//   id_rs1/id_rs2 (+uses)   source registers of the instruction in ID
//   ex_rd, ex_mem_read      destination register, and "is a load", for EX
//   ex_branch_taken         branch/jump resolved taken in EX
//   imem_ready, dmem_busy   memory handshakes
//   pc_write, if_id_write   register load enables
//   if_id_flush,id_ex_flush bubble insertion
//   pipe_hold               EX/MEM and MEM/WB hold
//   state                   FSM state (RUN / DFREEZE / REDIRECT)
//   stall_cnt, flush_cnt    saturating performance counters
//   timeout_err             sticky data-memory timeout flag
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int CNT_W      = 16,
   parameter int FREEZE_MAX = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_busy,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pipe_hold,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             timeout_err
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      DFREEZE  = 2'b01,
      REDIRECT = 2'b10,
      ILLEGAL  = 2'b11
   } state_t;

   localparam int FRZ_W = (FREEZE_MAX < 1) ? 1 : $clog2(FREEZE_MAX + 1);
   localparam logic [FRZ_W-1:0] FRZ_MAX  = FRZ_W'(FREEZE_MAX);
   // The flag is registered, so it is armed one count early. It then becomes
   // visible right after the FREEZE_MAX-th busy edge.
   localparam logic [FRZ_W-1:0] FRZ_LAST = FRZ_W'(FREEZE_MAX - 1);

   state_t           cur_state, nxt_state;
   logic             load_use;
   logic             flush_evt;
   logic [FRZ_W-1:0] frz_cnt;

   assign state = cur_state;

   assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));

   // Next state and outputs, in priority order:
   // reset > dmem_busy > branch > load_use > !imem_ready > normal.
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_hold   = 1'b0;
      flush_evt   = 1'b0;
      // REDIRECT waits for the fetch to come back. DFREEZE and the unused
      // encoding fall back to RUN.
      nxt_state   = (cur_state == REDIRECT && !imem_ready) ? REDIRECT : RUN;

      if (!reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         nxt_state   = RUN;
      end else if (dmem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
         nxt_state   = DFREEZE;
      end else if (ex_branch_taken) begin
         // IF/ID loads the NOP, and the PC takes the branch target.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         flush_evt   = 1'b1;
         nxt_state   = imem_ready ? RUN : REDIRECT;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
         // Fetch not valid: hold the PC and feed a NOP into ID.
         pc_write    = 1'b0;
         if_id_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cur_state <= RUN;
      else        cur_state <= nxt_state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
         if (flush_evt && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   // Consecutive busy-cycle counter. It clears as soon as busy drops, and it
   // parks at FREEZE_MAX so a long freeze cannot wrap it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frz_cnt     <= '0;
         timeout_err <= 1'b0;
      end else if (!dmem_busy) begin
         frz_cnt <= '0;
      end else begin
         if (frz_cnt != FRZ_MAX) frz_cnt <= frz_cnt + 1'b1;
         if (frz_cnt >= FRZ_LAST) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, imem_ready, dmem_busy;
   logic       pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, timeout_err;
   logic [1:0] state;
   logic [15:0] stall_cnt, flush_cnt;
   logic       s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_pipe_hold, s_timeout_err;
   logic [1:0] s_state;
   logic [3:0] s_stall_cnt, s_flush_cnt;
   logic [4:0] ctl;
   int         tests = 0;
   int         fails = 0;

   // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
   assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(16), .FREEZE_MAX(255)) dut (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .imem_ready(imem_ready), .dmem_busy(dmem_busy), .pc_write(pc_write),
      .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .pipe_hold(pipe_hold), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .timeout_err(timeout_err));

   pipeline_hazard_ctrl #(.CNT_W(4), .FREEZE_MAX(255)) u_sat (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .imem_ready(imem_ready), .dmem_busy(dmem_busy), .pc_write(s_pc_write),
      .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
      .pipe_hold(s_pipe_hold), .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
      .timeout_err(s_timeout_err));

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
   endtask

   task automatic lu();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
   endtask

   // Leaves the bench just after a negedge, with reset released and counters at zero.
   task automatic do_reset();
      @(negedge clk);
      idle();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      imem_ready = 1'b0;
      #2;
      tests++; if (ctl !== 5'b00110) begin fails++; $display("FAIL rst_ctl got %b exp 00110", ctl); end
      tests++; if ({state, stall_cnt, flush_cnt, timeout_err} !== 35'd0) begin fails++;
         $display("FAIL rst_regs got st=%0d stall=%0d flush=%0d to=%b exp all 0", state, stall_cnt, flush_cnt, timeout_err); end
      @(negedge clk); #1;
      tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL rst_hold_stall got %0d exp 0", stall_cnt); end
      reset = 1'b1; imem_ready = 1'b1; #1;
      tests++; if (ctl !== 5'b11000) begin fails++; $display("FAIL normal_ctl got %b exp 11000", ctl); end
      @(negedge clk); #1;
      tests++; if (stall_cnt !== 16'd0 || state !== 2'd0) begin fails++;
         $display("FAIL normal_regs got stall=%0d st=%0d exp 0 0", stall_cnt, state); end
   endtask

   task automatic test_load_use();
      do_reset();
      lu(); #1;
      tests++; if (ctl !== 5'b00010) begin fails++; $display("FAIL lu_ctl got %b exp 00010", ctl); end
      @(negedge clk); idle(); #1;
      tests++; if (ctl !== 5'b11000 || stall_cnt !== 16'd1 || state !== 2'd0) begin fails++;
         $display("FAIL lu_after got ctl=%b stall=%0d st=%0d exp 11000 1 0", ctl, stall_cnt, state); end
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; #1;
      tests++; if (ctl !== 5'b11000) begin fails++; $display("FAIL lu_x0_ctl got %b exp 11000", ctl); end
      @(negedge clk); idle();
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; #1;
      tests++; if (ctl !== 5'b00010) begin fails++; $display("FAIL lu_rs2_ctl got %b exp 00010", ctl); end
      @(negedge clk); idle();
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; #1;
      tests++; if (ctl !== 5'b11000) begin fails++; $display("FAIL lu_unused_ctl got %b exp 11000", ctl); end
      @(negedge clk); idle(); #1;
      tests++; if (stall_cnt !== 16'd2) begin fails++; $display("FAIL lu_stall_cnt got %0d exp 2", stall_cnt); end
   endtask

   task automatic test_branch_redirect();
      do_reset();
      ex_branch_taken = 1'b1; imem_ready = 1'b0; #1;
      tests++; if (ctl !== 5'b11110) begin fails++; $display("FAIL br_ctl got %b exp 11110", ctl); end
      @(negedge clk);
      ex_branch_taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (state !== 2'd2 || ctl !== 5'b01100) begin fails++;
            $display("FAIL redir_%0d got st=%0d ctl=%b exp 2 01100", i, state, ctl); end
         @(negedge clk);
      end
      imem_ready = 1'b1; #1;
      tests++; if (state !== 2'd2 || ctl !== 5'b11000) begin fails++;
         $display("FAIL redir_exit got st=%0d ctl=%b exp 2 11000", state, ctl); end
      @(negedge clk); #1;
      tests++; if (state !== 2'd0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin fails++;
         $display("FAIL redir_end got st=%0d flush=%0d stall=%0d exp 0 1 3", state, flush_cnt, stall_cnt); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      lu(); ex_branch_taken = 1'b1; dmem_busy = 1'b1; #1;
      tests++; if (ctl !== 5'b00001) begin fails++; $display("FAIL sim_busy_ctl got %b exp 00001", ctl); end
      @(negedge clk); dmem_busy = 1'b0; #1;
      tests++; if (state !== 2'd1 || ctl !== 5'b11110) begin fails++;
         $display("FAIL sim_branch got st=%0d ctl=%b exp 1 11110", state, ctl); end
      @(negedge clk); idle(); #1;
      tests++; if (state !== 2'd0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin fails++;
         $display("FAIL sim_end got st=%0d flush=%0d stall=%0d exp 0 1 1", state, flush_cnt, stall_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      dmem_busy = 1'b1;
      repeat (200) @(negedge clk);
      dmem_busy = 1'b0;
      @(negedge clk);
      dmem_busy = 1'b1;
      repeat (200) @(negedge clk);
      #1;
      tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_cleared got %b exp 0", timeout_err); end
      dmem_busy = 1'b0;
      @(negedge clk);
      dmem_busy = 1'b1;
      repeat (254) @(negedge clk);
      #1;
      tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_254 got %b exp 0", timeout_err); end
      @(negedge clk); #1;
      tests++; if (timeout_err !== 1'b1 || ctl !== 5'b00001) begin fails++;
         $display("FAIL to_255 got to=%b ctl=%b exp 1 00001", timeout_err, ctl); end
      dmem_busy = 1'b0;
      @(negedge clk); #1;
      tests++; if (timeout_err !== 1'b1 || state !== 2'd0 || stall_cnt !== 16'd655) begin fails++;
         $display("FAIL to_sticky got to=%b st=%0d stall=%0d exp 1 0 655", timeout_err, state, stall_cnt); end
   endtask

   task automatic test_saturation();
      do_reset();
      imem_ready = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      tests++; if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin fails++;
         $display("FAIL sat_stall got small=%0d wide=%0d exp 15 20", s_stall_cnt, stall_cnt); end
      idle(); ex_branch_taken = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      tests++; if (s_flush_cnt !== 4'd15 || flush_cnt !== 16'd20 || s_stall_cnt !== 4'd15) begin fails++;
         $display("FAIL sat_flush got small=%0d wide=%0d sstall=%0d exp 15 20 15", s_flush_cnt, flush_cnt, s_stall_cnt); end
   endtask

   task automatic test_reset_async();
      do_reset();
      ex_branch_taken = 1'b1; imem_ready = 1'b0;
      @(negedge clk);
      ex_branch_taken = 1'b0; #1;
      tests++; if (state !== 2'd2 || flush_cnt !== 16'd1) begin fails++;
         $display("FAIL ar_pre got st=%0d flush=%0d exp 2 1", state, flush_cnt); end
      #2 reset = 1'b0; #1;
      tests++; if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || ctl !== 5'b00110) begin fails++;
         $display("FAIL ar_mid got st=%0d stall=%0d flush=%0d ctl=%b exp 0 0 0 00110", state, stall_cnt, flush_cnt, ctl); end
      @(negedge clk);
      reset = 1'b1; #1;
      tests++; if (state !== 2'd0 || ctl !== 5'b01100) begin fails++;
         $display("FAIL ar_release got st=%0d ctl=%b exp 0 01100", state, ctl); end
      @(negedge clk); #1;
      tests++; if (state !== 2'd0 || stall_cnt !== 16'd1) begin fails++;
         $display("FAIL ar_from_run got st=%0d stall=%0d exp 0 1", state, stall_cnt); end
      idle(); dmem_busy = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0; #1;
      tests++; if (state !== 2'd0 || stall_cnt !== 16'd0) begin fails++;
         $display("FAIL ar_dfreeze got st=%0d stall=%0d exp 0 0", state, stall_cnt); end
      @(negedge clk);
      idle(); reset = 1'b1;
      @(negedge clk); #1;
      tests++; if (state !== 2'd0 || stall_cnt !== 16'd0 || ctl !== 5'b11000) begin fails++;
         $display("FAIL ar_dfreeze_after got st=%0d stall=%0d ctl=%b exp 0 0 11000", state, stall_cnt, ctl); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load_use();
      test_branch_redirect();
      test_simultaneous();
      test_timeout();
      test_saturation();
      test_reset_async();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-002 SHALL have parameter FREEZE_MAX, default 255: data-memory wait cycles before a timeout error.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  qualifiers for id_rs1 and id_rs2.
REQ-007 SHALL have port ex_rd  input  5  destination register of the instruction in EX.
REQ-008 SHALL have port ex_mem_read  input  1  instruction in EX is a load.
REQ-009 SHALL have port ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-010 SHALL have port imem_ready  input  1  instruction fetched this cycle is valid.
REQ-011 SHALL have port dmem_busy  input  1  MEM-stage access not complete.
REQ-012 SHALL have port pc_write  output  1  PC update enable.
REQ-013 SHALL have port if_id_write  output  1  IF/ID register load enable.
REQ-014 SHALL have port if_id_flush  output  1  IF/ID register loads NOP (0x00000013) and PC 0.
REQ-015 SHALL have port id_ex_flush  output  1  ID/EX register loads a bubble.
REQ-016 SHALL have port pipe_hold  output  1  EX/MEM and MEM/WB registers hold.
REQ-017 SHALL have port state  output  2  current FSM state.
REQ-018 SHALL have port stall_cnt  output  CNT_W  total stall and freeze cycles.
REQ-019 SHALL have port flush_cnt  output  CNT_W  taken-branch flush events.
REQ-020 SHALL have port timeout_err  output  1  sticky data-memory timeout flag.

Function
REQ-021 SHALL implement states RUN=2'b00, DFREEZE=2'b01, REDIRECT=2'b10; 2'b11 SHALL recover to RUN on the next edge.
REQ-022 SHALL compute load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-023 SHALL drive outputs combinationally from state and inputs (Mealy) with zero-cycle latency; the per-cycle priority SHALL be dmem_busy > ex_branch_taken > load_use > !imem_ready > normal.
REQ-024 dmem_busy in any state SHALL force pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=0, pipe_hold=1, and next state DFREEZE.
REQ-025 In DFREEZE with dmem_busy=0, the block SHALL return to RUN on the next edge; outputs in that cycle SHALL follow the RUN rules.
REQ-026 ex_branch_taken (no dmem_busy) SHALL force pc_write=1, if_id_flush=1, id_ex_flush=1, and increment flush_cnt.
REQ-027 After a taken branch, the next state SHALL be REDIRECT if imem_ready=0, else RUN.
REQ-028 A load_use hazard (no higher priority event) SHALL force pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle, with state unchanged.
REQ-029 imem_ready=0 (no higher priority event) SHALL force pc_write=0, if_id_write=1, if_id_flush=1.
REQ-030 In REDIRECT, the block SHALL stay until imem_ready=1, then go to RUN.
REQ-031 Normal operation SHALL drive pc_write=1, if_id_write=1, and all flush and hold outputs 0.
REQ-032 stall_cnt SHALL increment in every cycle where pc_write=0; both counters SHALL saturate at all-ones and never wrap.
REQ-033 A freeze counter SHALL count consecutive dmem_busy cycles; when it reaches FREEZE_MAX, timeout_err SHALL set and stay set until reset, and the freeze SHALL continue.
REQ-034 The freeze counter SHALL clear whenever dmem_busy=0.

Reset
REQ-035 reset=0 SHALL immediately set state=RUN and zero stall_cnt, flush_cnt, the freeze counter and timeout_err, regardless of clk.
REQ-036 While reset=0, outputs SHALL be pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0.
REQ-037 Reset asserted mid-DFREEZE or mid-REDIRECT SHALL discard that state; the first edge after release SHALL evaluate from RUN.

Verification
REQ-038 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1. The same pattern with ex_rd=0 -> no stall.
REQ-039 Branch with slow fetch: ex_branch_taken=1, then imem_ready=0 for 3 cycles -> flush in cycle 0, state=REDIRECT for 3 cycles with if_id_flush=1, then RUN; flush_cnt=1, stall_cnt=3.
REQ-040 Simultaneous events: dmem_busy=1 with ex_branch_taken=1 and load_use -> pipe_hold=1 only, no flush; after dmem_busy drops, the branch flush occurs.
REQ-041 Timeout: dmem_busy held 255 cycles (FREEZE_MAX=255) -> timeout_err rises on the 255th cycle and stays 1 after dmem_busy drops.
REQ-042 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15.
REQ-043 Reset: reset pulled low asynchronously mid-REDIRECT -> state=RUN, counters 0 before the next clk edge.
